// File: rtl/fsm_seq_decoder.sv
// fsm_seq_decoder
//   Receive-side checker/decoder for the 5-state sequence generator stream
//   (codes 2,4,6,7,3). Validates each symbol-to-symbol transition against the
//   generator's legal graph, hunts/checks/locks onto the stream, recovers the
//   input bit 'a' on branching transitions and counts errors while locked.
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   sym_in     observed generator symbol
//   sym_valid  sym_in is sampled on this edge when 1
//   a_out      decoded input bit (qualified by a_valid)
//   a_valid    one-cycle pulse: a_out carries a decoded bit
//   locked     1 while in LOCKED
//   sync_st    00 HUNT, 01 CHECK, 10 LOCKED
//   err_pulse  one-cycle pulse on an illegal transition while LOCKED
//   err_count  saturating count of LOCKED-mode illegal transitions
module fsm_seq_decoder #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sym_in,
  input  logic             sym_valid,
  output logic             a_out,
  output logic             a_valid,
  output logic             locked,
  output logic [1:0]       sync_st,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    CHECK  = 2'b01,
    LOCKED = 2'b10
  } st_e;

  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_V = 4'(LOSS_CNT);

  st_e              st_q, st_d;
  logic [2:0]       prev_q, prev_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic             a_out_q, a_out_d;
  logic             a_valid_q, a_valid_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  function automatic logic sym_ok(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4) || (s == 3'd6) || (s == 3'd7);
  endfunction

  // Edges of the generator graph. An illegal prev has no outgoing edge, so a
  // corrupted symbol held in prev always makes the following transition fail.
  function automatic logic trans_ok(input logic [2:0] p, input logic [2:0] s);
    case (p)
      3'd2:    return s == 3'd4;
      3'd4:    return (s == 3'd3) || (s == 3'd6);
      3'd6:    return s == 3'd7;
      3'd3:    return s == 3'd6;
      3'd7:    return (s == 3'd4) || (s == 3'd2);
      default: return 1'b0;
    endcase
  endfunction

  logic       tr_legal;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;

  assign tr_legal = trans_ok(prev_q, sym_in);
  assign good_inc = good_q + 4'd1;
  assign bad_inc  = bad_q + 4'd1;

  always_comb begin
    st_d        = st_q;
    prev_d      = prev_q;
    good_d      = good_q;
    bad_d       = bad_q;
    a_out_d     = 1'b0;
    a_valid_d   = 1'b0;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    if (sym_valid) begin
      case (st_q)
        HUNT: begin
          if (sym_ok(sym_in)) begin
            prev_d = sym_in;
            good_d = '0;
            st_d   = CHECK;
          end
        end
        CHECK: begin
          prev_d = sym_in;
          if (tr_legal) begin
            good_d = good_inc;
            if (good_inc == LOCK_V) begin
              st_d  = LOCKED;
              bad_d = '0;
            end
          end else begin
            good_d = '0;
            if (!sym_ok(sym_in)) st_d = HUNT;
          end
        end
        LOCKED: begin
          prev_d = sym_in;
          if (tr_legal) begin
            bad_d = '0;
            // Only 4 and 7 branch on 'a'; the other edges carry no information.
            if (prev_q == 3'd4) begin
              a_valid_d = 1'b1;
              a_out_d   = (sym_in == 3'd3);
            end else if (prev_q == 3'd7) begin
              a_valid_d = 1'b1;
              a_out_d   = (sym_in == 3'd4);
            end
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            bad_d = bad_inc;
            if (bad_inc == LOSS_V) begin
              st_d   = HUNT;
              good_d = '0;
              bad_d  = '0;
            end
          end
        end
        default: st_d = HUNT;
      endcase
    end
    locked_d = (st_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= HUNT;
      prev_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      a_out_q     <= 1'b0;
      a_valid_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      st_q        <= st_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      a_out_q     <= a_out_d;
      a_valid_q   <= a_valid_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign a_out     = a_out_q;
  assign a_valid   = a_valid_q;
  assign locked    = locked_q;
  assign sync_st   = st_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_fsm_seq_decoder.sv
// Bench for fsm_seq_decoder: two instances (default parameters, and a narrow
// saturating counter with LOSS_CNT=15) share one stimulus stream. A model
// built on the generator's next-state function predicts every output.
module tb_fsm_seq_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sym_in = 3'd0;
  logic       sym_valid = 1'b0;

  logic       a_out0, a_valid0, locked0, err_pulse0;
  logic [1:0] sync_st0;
  logic [7:0] err_count0;
  logic       a_out1, a_valid1, locked1, err_pulse1;
  logic [1:0] sync_st1;
  logic [1:0] err_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_seq_decoder #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .a_out(a_out0), .a_valid(a_valid0), .locked(locked0), .sync_st(sync_st0),
    .err_pulse(err_pulse0), .err_count(err_count0));

  fsm_seq_decoder #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .a_out(a_out1), .a_valid(a_valid1), .locked(locked1), .sync_st(sync_st1),
    .err_pulse(err_pulse1), .err_count(err_count1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Generator next state for (state, a); -1 for codes outside the generator.
  function automatic int gen_next(input int p, input int a);
    case (p)
      2:       return 4;
      4:       return a ? 3 : 6;
      6:       return 7;
      7:       return a ? 4 : 2;
      3:       return 6;
      default: return -1;
    endcase
  endfunction

  function automatic bit is_code(input int s);
    return gen_next(s, 0) != -1;
  endfunction

  int m_mode[2], m_prev[2], m_good[2], m_bad[2], m_cnt[2];
  bit e_aout[2], e_av[2], e_ep[2];
  int lock_n[2] = '{4, 4};
  int loss_n[2] = '{3, 15};
  int cnt_max[2] = '{255, 3};

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_prev[i] = 0; m_good[i] = 0; m_bad[i] = 0; m_cnt[i] = 0;
      e_aout[i] = 0; e_av[i] = 0; e_ep[i] = 0;
    end
  endtask

  task automatic m_step(input int i, input int s);
    bit legal;
    legal = (gen_next(m_prev[i], 0) == s) || (gen_next(m_prev[i], 1) == s);
    e_av[i] = 0; e_ep[i] = 0; e_aout[i] = 0;
    if (m_mode[i] == 0) begin
      if (is_code(s)) begin m_prev[i] = s; m_good[i] = 0; m_mode[i] = 1; end
    end else if (m_mode[i] == 1) begin
      if (legal) begin
        m_good[i]++;
        if (m_good[i] == lock_n[i]) begin m_mode[i] = 2; m_bad[i] = 0; end
      end else begin
        m_good[i] = 0;
        if (!is_code(s)) m_mode[i] = 0;
      end
      m_prev[i] = s;
    end else begin
      if (legal) begin
        m_bad[i] = 0;
        // A branch point is where the two values of 'a' lead to different symbols.
        if (gen_next(m_prev[i], 0) != gen_next(m_prev[i], 1)) begin
          e_av[i] = 1;
          e_aout[i] = (gen_next(m_prev[i], 1) == s);
        end
      end else begin
        e_ep[i] = 1;
        if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        m_bad[i]++;
        if (m_bad[i] == loss_n[i]) begin m_mode[i] = 0; m_good[i] = 0; m_bad[i] = 0; end
      end
      m_prev[i] = s;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else if (sym_valid) begin
        m_step(0, int'(sym_in));
        m_step(1, int'(sym_in));
      end else begin
        for (int i = 0; i < 2; i++) begin e_av[i] = 0; e_ep[i] = 0; e_aout[i] = 0; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("a_valid0", a_valid0, e_av[0]);
      if (e_av[0]) chk("a_out0", a_out0, e_aout[0]);
      chk("err_pulse0", err_pulse0, e_ep[0]);
      chk("sync_st0", sync_st0, m_mode[0]);
      chk("locked0", locked0, m_mode[0] == 2);
      chk("err_count0", err_count0, m_cnt[0]);
      chk("a_valid1", a_valid1, e_av[1]);
      if (e_av[1]) chk("a_out1", a_out1, e_aout[1]);
      chk("err_pulse1", err_pulse1, e_ep[1]);
      chk("sync_st1", sync_st1, m_mode[1]);
      chk("locked1", locked1, m_mode[1] == 2);
      chk("err_count1", err_count1, m_cnt[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int s, input bit v);
    @(negedge clk);
    sym_in = 3'(s);
    sym_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    sym_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  int g;
  int s;

  initial begin
    #1;
    chk("rst_sync_st", sync_st0, 0);
    chk("rst_err_count", err_count0, 0);
    do_reset();

    // 1: a=0 stream, lock after the 5th symbol
    send(2, 1); send(4, 1); send(6, 1); send(7, 1);
    chk("t1_not_locked_4th", locked0, 0);
    chk("t1_check_state", sync_st0, 1);
    send(2, 1);
    chk("t1_locked_5th", locked0, 1);
    chk("t1_sync_locked", sync_st0, 2);
    send(4, 1);
    chk("t1_no_av_2to4", a_valid0, 0);
    send(6, 1);
    chk("t1_av_4to6", a_valid0, 1);
    chk("t1_a0_4to6", a_out0, 0);
    send(7, 1);
    send(2, 1);
    chk("t1_av_7to2", a_valid0, 1);
    chk("t1_a0_7to2", a_out0, 0);

    // 2: a=1 stream
    send(4, 1);
    send(3, 1);
    chk("t2_av_4to3", a_valid0, 1);
    chk("t2_a1_4to3", a_out0, 1);
    send(6, 1); send(7, 1);
    send(4, 1);
    chk("t2_a1_7to4", a_out0, 1);
    send(3, 1);
    chk("t2_no_errors", err_count0, 0);

    // 3: single illegal 5 between 6 and 7
    send(6, 1);
    send(5, 1);
    chk("t3_ep_6to5", err_pulse0, 1);
    chk("t3_cnt1", err_count0, 1);
    send(7, 1);
    chk("t3_ep_5to7", err_pulse0, 1);
    chk("t3_cnt2", err_count0, 2);
    chk("t3_still_locked", locked0, 1);
    send(2, 1);
    chk("t3_av_7to2", a_valid0, 1);
    chk("t3_a0_7to2", a_out0, 0);
    chk("t3_ep_clear", err_pulse0, 0);

    // 4: three illegal transitions drop to HUNT; 5 saturates the narrow counter
    send(0, 1); send(0, 1);
    chk("t4_locked_after_2", locked0, 1);
    send(0, 1);
    chk("t4_ep3", err_pulse0, 1);
    chk("t4_hunt", sync_st0, 0);
    chk("t4_cnt5", err_count0, 5);
    chk("t5_sat_cnt", err_count1, 3);
    chk("t5_sat_locked", locked1, 1);
    send(2, 1); send(4, 1); send(6, 1); send(7, 1); send(2, 1);
    chk("t4_relock", locked0, 1);

    // 6: idle edges and mid-CHECK reset
    send(4, 1);
    send(6, 0);
    chk("t6_idle_no_av", a_valid0, 0);
    chk("t6_idle_hold", locked0, 1);
    send(6, 1);
    chk("t6_av_after_idle", a_valid0, 1);
    do_reset();
    send(2, 1);
    send(4, 1);
    chk("t6_in_check", sync_st0, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_hunt", sync_st0, 0);
    chk("t6_rst_cnt", err_count0, 0);
    chk("t6_rst_av", a_valid0, 0);
    @(posedge clk); #2;
    reset = 1'b1;

    // random stream: mostly a valid generator walk with injected corruption
    g = 2;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      if ($urandom_range(0, 99) < 8) begin
        s = int'($urandom_range(0, 7));
        if (is_code(s)) g = s;
      end else begin
        g = gen_next(g, int'($urandom_range(0, 1)));
        s = g;
      end
      send(s, $urandom_range(0, 99) < 85);
    end
    send(0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
